// File: rtl/easyaxi_rd_slice.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_slice
// Brief    : AXI read-path register slice (AR and R skid buffers) with an
//            outstanding-burst counter, issue cap and orphan-`last` error flag.
// Revision : 1.0 - initial release
// ============================================================================

module easyaxi_rd_slice_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_main_v;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_main_free;

    // Ready depends only on skid occupancy, so no input reaches it combinationally.
    assign o_ready     = !r_skid_v;
    assign o_valid     = r_main_v;
    assign o_data      = r_main_data;
    assign w_in_fire   = i_valid && !r_skid_v;
    assign w_main_free = !r_main_v || i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_v    <= 1'b0;
            r_main_data <= '0;
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
        end else if (w_main_free) begin
            if (r_skid_v) begin
                r_main_v    <= 1'b1;
                r_main_data <= r_skid_data;
                r_skid_v    <= 1'b0;
            end else if (w_in_fire) begin
                r_main_v    <= 1'b1;
                r_main_data <= i_data;
            end else begin
                r_main_v    <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_v    <= 1'b1;
            r_skid_data <= i_data;
        end
    end

endmodule

module easyaxi_rd_slice #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int SIZE_W  = 3,
    parameter int BURST_W = 2,
    parameter int USER_W  = 4,
    parameter int DATA_W  = 32,
    parameter int RESP_W  = 2,
    parameter int MAX_OS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    // AR from master
    input  logic               axi_slv_arvalid,
    output logic               axi_slv_arready,
    input  logic [ID_W-1:0]    axi_slv_arid,
    input  logic [ADDR_W-1:0]  axi_slv_araddr,
    input  logic [LEN_W-1:0]   axi_slv_arlen,
    input  logic [SIZE_W-1:0]  axi_slv_arsize,
    input  logic [BURST_W-1:0] axi_slv_arburst,
    input  logic [USER_W-1:0]  axi_slv_aruser,
    // AR to slave
    output logic               axi_mst_arvalid,
    input  logic               axi_mst_arready,
    output logic [ID_W-1:0]    axi_mst_arid,
    output logic [ADDR_W-1:0]  axi_mst_araddr,
    output logic [LEN_W-1:0]   axi_mst_arlen,
    output logic [SIZE_W-1:0]  axi_mst_arsize,
    output logic [BURST_W-1:0] axi_mst_arburst,
    output logic [USER_W-1:0]  axi_mst_aruser,
    // R from slave
    input  logic               axi_mst_rvalid,
    output logic               axi_mst_rready,
    input  logic [ID_W-1:0]    axi_mst_rid,
    input  logic [DATA_W-1:0]  axi_mst_rdata,
    input  logic [RESP_W-1:0]  axi_mst_rresp,
    input  logic               axi_mst_rlast,
    input  logic [USER_W-1:0]  axi_mst_ruser,
    // R to master
    output logic               axi_slv_rvalid,
    input  logic               axi_slv_rready,
    output logic [ID_W-1:0]    axi_slv_rid,
    output logic [DATA_W-1:0]  axi_slv_rdata,
    output logic [RESP_W-1:0]  axi_slv_rresp,
    output logic               axi_slv_rlast,
    output logic [USER_W-1:0]  axi_slv_ruser,
    // Status
    output logic [3:0]         rd_os_cnt,
    output logic               rd_os_err
);

    localparam int         C_AR_W   = ID_W + ADDR_W + LEN_W + SIZE_W + BURST_W + USER_W;
    localparam int         C_R_W    = ID_W + DATA_W + RESP_W + 1 + USER_W;
    localparam logic [3:0] C_MAX_OS = 4'(MAX_OS);

    logic [C_AR_W-1:0] w_ar_in;
    logic [C_AR_W-1:0] w_ar_out;
    logic [C_R_W-1:0]  w_r_in;
    logic [C_R_W-1:0]  w_r_out;
    logic              w_os_ok;
    logic              w_ar_slice_ready;
    logic              w_ar_hs;
    logic              w_r_last_hs;
    logic [3:0]        r_os_cnt;
    logic              r_os_err;

    assign w_os_ok = (r_os_cnt < C_MAX_OS);
    assign w_ar_in = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
                      axi_slv_arsize, axi_slv_arburst, axi_slv_aruser};
    assign {axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
            axi_mst_arsize, axi_mst_arburst, axi_mst_aruser} = w_ar_out;

    // The cap blocks the AR input so a held request waits upstream.
    easyaxi_rd_slice_skid #(.WIDTH(C_AR_W)) u_ar_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (axi_slv_arvalid && w_os_ok),
        .o_ready (w_ar_slice_ready),
        .i_data  (w_ar_in),
        .o_valid (axi_mst_arvalid),
        .i_ready (axi_mst_arready),
        .o_data  (w_ar_out)
    );

    assign axi_slv_arready = w_ar_slice_ready && w_os_ok;

    assign w_r_in = {axi_mst_rid, axi_mst_rdata, axi_mst_rresp,
                     axi_mst_rlast, axi_mst_ruser};
    assign {axi_slv_rid, axi_slv_rdata, axi_slv_rresp,
            axi_slv_rlast, axi_slv_ruser} = w_r_out;

    easyaxi_rd_slice_skid #(.WIDTH(C_R_W)) u_r_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (axi_mst_rvalid),
        .o_ready (axi_mst_rready),
        .i_data  (w_r_in),
        .o_valid (axi_slv_rvalid),
        .i_ready (axi_slv_rready),
        .o_data  (w_r_out)
    );

    assign w_ar_hs     = axi_slv_arvalid && axi_slv_arready;
    assign w_r_last_hs = axi_slv_rvalid && axi_slv_rready && axi_slv_rlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_os_cnt <= 4'd0;
            r_os_err <= 1'b0;
        end else if (w_ar_hs && !w_r_last_hs) begin
            r_os_cnt <= r_os_cnt + 4'd1;
        end else if (!w_ar_hs && w_r_last_hs) begin
            // An orphan `last` leaves the count at zero and latches the error.
            if (r_os_cnt == 4'd0) begin
                r_os_err <= 1'b1;
            end else begin
                r_os_cnt <= r_os_cnt - 4'd1;
            end
        end
    end

    assign rd_os_cnt = r_os_cnt;
    assign rd_os_err = r_os_err;

endmodule

`default_nettype wire

// File: tb/tb_easyaxi_rd_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_easyaxi_rd_slice
// Brief    : Directed and random checks of easyaxi_rd_slice against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_easyaxi_rd_slice;

    localparam int AR_W   = 53;
    localparam int R_W    = 43;
    localparam int MAX_OS = 4;

    logic        clk;
    logic        rst_n;
    logic        axi_slv_arvalid;
    logic        axi_slv_arready;
    logic [3:0]  axi_slv_arid;
    logic [31:0] axi_slv_araddr;
    logic [7:0]  axi_slv_arlen;
    logic [2:0]  axi_slv_arsize;
    logic [1:0]  axi_slv_arburst;
    logic [3:0]  axi_slv_aruser;
    logic        axi_mst_arvalid;
    logic        axi_mst_arready;
    logic [3:0]  axi_mst_arid;
    logic [31:0] axi_mst_araddr;
    logic [7:0]  axi_mst_arlen;
    logic [2:0]  axi_mst_arsize;
    logic [1:0]  axi_mst_arburst;
    logic [3:0]  axi_mst_aruser;
    logic        axi_mst_rvalid;
    logic        axi_mst_rready;
    logic [3:0]  axi_mst_rid;
    logic [31:0] axi_mst_rdata;
    logic [1:0]  axi_mst_rresp;
    logic        axi_mst_rlast;
    logic [3:0]  axi_mst_ruser;
    logic        axi_slv_rvalid;
    logic        axi_slv_rready;
    logic [3:0]  axi_slv_rid;
    logic [31:0] axi_slv_rdata;
    logic [1:0]  axi_slv_rresp;
    logic        axi_slv_rlast;
    logic [3:0]  axi_slv_ruser;
    logic [3:0]  rd_os_cnt;
    logic        rd_os_err;

    easyaxi_rd_slice dut (
        .clk(clk), .rst_n(rst_n),
        .axi_slv_arvalid(axi_slv_arvalid), .axi_slv_arready(axi_slv_arready),
        .axi_slv_arid(axi_slv_arid), .axi_slv_araddr(axi_slv_araddr),
        .axi_slv_arlen(axi_slv_arlen), .axi_slv_arsize(axi_slv_arsize),
        .axi_slv_arburst(axi_slv_arburst), .axi_slv_aruser(axi_slv_aruser),
        .axi_mst_arvalid(axi_mst_arvalid), .axi_mst_arready(axi_mst_arready),
        .axi_mst_arid(axi_mst_arid), .axi_mst_araddr(axi_mst_araddr),
        .axi_mst_arlen(axi_mst_arlen), .axi_mst_arsize(axi_mst_arsize),
        .axi_mst_arburst(axi_mst_arburst), .axi_mst_aruser(axi_mst_aruser),
        .axi_mst_rvalid(axi_mst_rvalid), .axi_mst_rready(axi_mst_rready),
        .axi_mst_rid(axi_mst_rid), .axi_mst_rdata(axi_mst_rdata),
        .axi_mst_rresp(axi_mst_rresp), .axi_mst_rlast(axi_mst_rlast),
        .axi_mst_ruser(axi_mst_ruser),
        .axi_slv_rvalid(axi_slv_rvalid), .axi_slv_rready(axi_slv_rready),
        .axi_slv_rid(axi_slv_rid), .axi_slv_rdata(axi_slv_rdata),
        .axi_slv_rresp(axi_slv_rresp), .axi_slv_rlast(axi_slv_rlast),
        .axi_slv_ruser(axi_slv_ruser),
        .rd_os_cnt(rd_os_cnt), .rd_os_err(rd_os_err)
    );

    logic [AR_W-1:0] w_ar_in;
    logic [AR_W-1:0] w_ar_out;
    logic [R_W-1:0]  w_r_in;
    logic [R_W-1:0]  w_r_out;
    assign w_ar_in  = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arsize, axi_slv_arburst, axi_slv_aruser};
    assign w_ar_out = {axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst, axi_mst_aruser};
    assign w_r_in   = {axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast, axi_mst_ruser};
    assign w_r_out  = {axi_slv_rid, axi_slv_rdata, axi_slv_rresp, axi_slv_rlast, axi_slv_ruser};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each slice is a two-deep FIFO; counter tracks bursts.
    logic [AR_W-1:0] ar_q[$];
    logic [R_W-1:0]  r_q[$];
    int              m_cnt = 0;
    bit              m_err = 1'b0;
    bit              started = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        chk("arready", 64'(axi_slv_arready), 64'((ar_q.size() < 2) && (m_cnt < MAX_OS)));
        chk("mst_arvalid", 64'(axi_mst_arvalid), 64'(ar_q.size() > 0));
        if (ar_q.size() > 0) chk("ar_payload", 64'(w_ar_out), 64'(ar_q[0]));
        chk("mst_rready", 64'(axi_mst_rready), 64'(r_q.size() < 2));
        chk("slv_rvalid", 64'(axi_slv_rvalid), 64'(r_q.size() > 0));
        if (r_q.size() > 0) chk("r_payload", 64'(w_r_out), 64'(r_q[0]));
        chk("os_cnt", 64'(rd_os_cnt), 64'(m_cnt));
        chk("os_err", 64'(rd_os_err), 64'(m_err));
    endtask

    task automatic tick();
        bit h_ar_in, h_ar_out, h_r_in, h_r_out, h_dec;
        logic [AR_W-1:0] ar_v;
        logic [R_W-1:0]  r_v;
        @(negedge clk);
        if (started) model_check();
        h_ar_in  = axi_slv_arvalid && (ar_q.size() < 2) && (m_cnt < MAX_OS);
        h_ar_out = (ar_q.size() > 0) && axi_mst_arready;
        h_r_in   = axi_mst_rvalid && (r_q.size() < 2);
        h_r_out  = (r_q.size() > 0) && axi_slv_rready;
        h_dec    = h_r_out ? r_q[0][4] : 1'b0;
        ar_v     = w_ar_in;
        r_v      = w_r_in;
        @(posedge clk);
        if (!rst_n) begin
            ar_q.delete();
            r_q.delete();
            m_cnt   = 0;
            m_err   = 1'b0;
            started = 1'b1;
        end else begin
            if (h_ar_out) void'(ar_q.pop_front());
            if (h_ar_in)  ar_q.push_back(ar_v);
            if (h_r_out)  void'(r_q.pop_front());
            if (h_r_in)   r_q.push_back(r_v);
            if (h_ar_in && !h_dec) m_cnt++;
            else if (h_dec && !h_ar_in) begin
                if (m_cnt == 0) m_err = 1'b1;
                else m_cnt--;
            end
        end
        #1;
    endtask

    task automatic rand_inputs();
        axi_slv_arvalid = 1'($urandom_range(0, 1));
        axi_slv_arid    = 4'($urandom());
        axi_slv_araddr  = $urandom();
        axi_slv_arlen   = 8'($urandom());
        axi_slv_arsize  = 3'($urandom());
        axi_slv_arburst = 2'($urandom());
        axi_slv_aruser  = 4'($urandom());
        axi_mst_arready = 1'($urandom_range(0, 1));
        axi_mst_rvalid  = 1'($urandom_range(0, 1));
        axi_mst_rid     = 4'($urandom());
        axi_mst_rdata   = $urandom();
        axi_mst_rresp   = 2'($urandom());
        axi_mst_rlast   = ($urandom_range(0, 3) == 0);
        axi_mst_ruser   = 4'($urandom());
        axi_slv_rready  = 1'($urandom_range(0, 1));
    endtask

    task automatic r_beat(input logic [31:0] d, input logic last);
        axi_mst_rvalid = 1'b1;
        axi_mst_rdata  = d;
        axi_mst_rlast  = last;
        axi_mst_rid    = 4'($urandom());
        axi_mst_rresp  = 2'd0;
        axi_mst_ruser  = 4'($urandom());
    endtask

    initial begin
        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
        end
        chk("rst_mst_arvalid", 64'(axi_mst_arvalid), 64'd0);
        chk("rst_slv_rvalid", 64'(axi_slv_rvalid), 64'd0);
        chk("rst_cnt", 64'(rd_os_cnt), 64'd0);
        chk("rst_err", 64'(rd_os_err), 64'd0);
        chk("rst_arready", 64'(axi_slv_arready), 64'd1);
        chk("rst_rready", 64'(axi_mst_rready), 64'd1);
        chk("rst_ar_payload", 64'(w_ar_out), 64'd0);
        chk("rst_r_payload", 64'(w_r_out), 64'd0);

        rst_n = 1'b1;
        axi_slv_arvalid = 1'b0;
        axi_mst_rvalid  = 1'b0;
        axi_mst_arready = 1'b1;
        axi_slv_rready  = 1'b1;
        tick();

        // Streaming: one AR, four data beats
        axi_slv_arvalid = 1'b1;
        axi_slv_araddr  = 32'h1000;
        axi_slv_arlen   = 8'd3;
        tick();
        chk("stream_cnt_up", 64'(rd_os_cnt), 64'd1);
        chk("stream_ar_addr", 64'(axi_mst_araddr), 64'h1000);
        chk("stream_ar_len", 64'(axi_mst_arlen), 64'd3);
        axi_slv_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_beat(32'hA0 + 32'(i), (i == 3));
            tick();
            chk("stream_rvalid", 64'(axi_slv_rvalid), 64'd1);
            chk("stream_rdata", 64'(axi_slv_rdata), 64'(32'hA0 + 32'(i)));
            chk("stream_rlast", 64'(axi_slv_rlast), 64'(i == 3));
            chk("stream_cnt_hold", 64'(rd_os_cnt), 64'd1);
        end
        axi_mst_rvalid = 1'b0;
        tick();
        chk("stream_cnt_down", 64'(rd_os_cnt), 64'd0);
        chk("stream_idle", 64'(axi_slv_rvalid), 64'd0);

        // R backpressure
        axi_slv_rready = 1'b0;
        r_beat(32'h1, 1'b0);
        tick();
        chk("bp_rready_1", 64'(axi_mst_rready), 64'd1);
        r_beat(32'h2, 1'b0);
        tick();
        chk("bp_rready_2", 64'(axi_mst_rready), 64'd0);
        r_beat(32'h3, 1'b0);
        tick();
        chk("bp_rready_held", 64'(axi_mst_rready), 64'd0);
        chk("bp_hold_data", 64'(axi_slv_rdata), 64'h1);
        axi_slv_rready = 1'b1;
        tick();
        chk("bp_rel_data2", 64'(axi_slv_rdata), 64'h2);
        chk("bp_rel_rready", 64'(axi_mst_rready), 64'd1);
        tick();
        chk("bp_rel_data3", 64'(axi_slv_rdata), 64'h3);
        chk("bp_rel_valid3", 64'(axi_slv_rvalid), 64'd1);
        axi_mst_rvalid = 1'b0;
        tick();
        chk("bp_drained", 64'(axi_slv_rvalid), 64'd0);

        // Outstanding limit
        axi_slv_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            axi_slv_araddr = 32'h2000 + 32'(i * 16);
            tick();
        end
        chk("lim_cnt", 64'(rd_os_cnt), 64'd4);
        chk("lim_arready", 64'(axi_slv_arready), 64'd0);
        r_beat(32'hB0, 1'b1);
        tick();
        axi_mst_rvalid = 1'b0;
        chk("lim_cnt_pending", 64'(rd_os_cnt), 64'd4);
        tick();
        chk("lim_cnt_freed", 64'(rd_os_cnt), 64'd3);
        chk("lim_arready_up", 64'(axi_slv_arready), 64'd1);
        tick();
        chk("lim_fifth", 64'(rd_os_cnt), 64'd4);
        chk("lim_arready_dn", 64'(axi_slv_arready), 64'd0);
        axi_slv_arvalid = 1'b0;

        // Bring count to 2
        r_beat(32'hB1, 1'b1);
        tick();
        tick();
        axi_mst_rvalid = 1'b0;
        tick();
        chk("sim_pre_cnt", 64'(rd_os_cnt), 64'd2);

        // Simultaneous AR and `last` handshakes
        axi_slv_rready = 1'b0;
        r_beat(32'hC0, 1'b1);
        tick();
        axi_mst_rvalid  = 1'b0;
        axi_slv_rready  = 1'b1;
        axi_slv_arvalid = 1'b1;
        axi_slv_araddr  = 32'h3000;
        tick();
        axi_slv_arvalid = 1'b0;
        chk("sim_cnt", 64'(rd_os_cnt), 64'd2);

        // Drain to zero
        r_beat(32'hC1, 1'b1);
        tick();
        tick();
        axi_mst_rvalid = 1'b0;
        tick();
        chk("drain_cnt", 64'(rd_os_cnt), 64'd0);
        chk("drain_err", 64'(rd_os_err), 64'd0);

        // Orphan `last`
        r_beat(32'hEE, 1'b1);
        tick();
        axi_mst_rvalid = 1'b0;
        chk("err_pass_valid", 64'(axi_slv_rvalid), 64'd1);
        chk("err_pass_data", 64'(axi_slv_rdata), 64'hEE);
        tick();
        chk("err_set", 64'(rd_os_err), 64'd1);
        chk("err_cnt", 64'(rd_os_cnt), 64'd0);
        tick();
        tick();
        chk("err_sticky", 64'(rd_os_err), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("err_cleared", 64'(rd_os_err), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            if (i == 200) rst_n = 1'b0;
            else rst_n = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
